// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port 2048x32 SRAM with one-cycle read latency.
// Requests go straight to the SRAM; responses return in order through a small buffer.
module sram_req_ctrl #(
    parameter int AW         = 11,
    parameter int FIFO_DEPTH = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_is_write,
    output logic          mem_ce,
    output logic          mem_oce,
    output logic          mem_reset,
    output logic          mem_wre,
    output logic [AW-1:0] mem_ad,
    output logic [31:0]   mem_din,
    output logic [3:0]    mem_byte_en,
    input  logic [31:0]   mem_dout,
    output logic          busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_we_q, infl_we_d;
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] is_wr_q;

    logic                  push_s;
    logic                  pop_s;
    logic [31:0]           push_data_s;
    logic [CW:0]           occupancy_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Space accounting counts the in-flight slot so the SRAM result always has a home.
    assign occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req_ready   = (occupancy_s < DEPTH_W);

    assign mem_ce      = req_valid & req_ready;
    assign mem_wre     = req_we & mem_ce;
    assign mem_ad      = req_addr[AW+1:2];
    assign mem_din     = req_wdata;
    assign mem_byte_en = req_we ? req_wstrb : 4'b0000;
    assign mem_oce     = 1'b1;
    assign mem_reset   = 1'b0;

    assign push_s      = inflight_q;
    assign pop_s       = rsp_valid & rsp_ready;
    assign push_data_s = infl_we_q ? 32'h0000_0000 : mem_dout;

    assign rsp_valid    = (count_q != {CW{1'b0}});
    assign rsp_rdata    = rsp_valid ? data_q[rd_ptr_q] : 32'h0000_0000;
    assign rsp_is_write = rsp_valid ? is_wr_q[rd_ptr_q] : 1'b0;
    assign busy         = inflight_q | rsp_valid;

    // Next-state for occupancy, pointers and the in-flight marker.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = mem_ce;
        infl_we_d  = req_we & mem_ce;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        if (push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q    <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            inflight_q <= 1'b0;
            infl_we_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            infl_we_q  <= infl_we_d;
        end
    end

    // Response buffer storage, written at the end of the in-flight cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= 32'h0000_0000;
            end
            is_wr_q <= {FIFO_DEPTH{1'b0}};
        end else if (push_s) begin
            data_q[wr_ptr_q]  <= push_data_s;
            is_wr_q[wr_ptr_q] <= infl_we_q;
        end else begin
            is_wr_q <= is_wr_q;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural 2048x32 byte-enable SRAM attached.
module tb_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_is_write;
    logic [31:0] rsp_rdata;
    logic        mem_ce, mem_oce, mem_reset, mem_wre;
    logic [10:0] mem_ad;
    logic [31:0] mem_din, mem_dout;
    logic [3:0]  mem_byte_en;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] sram [2048];

    sram_req_ctrl #(.AW(11), .FIFO_DEPTH(3)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_is_write(rsp_is_write),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_reset(mem_reset), .mem_wre(mem_wre),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_byte_en(mem_byte_en),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous byte-lane write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byte_en[b]) sram[mem_ad][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end else begin
                mem_dout <= sram[mem_ad];
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        #3;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_is_write !== 1'b0) begin bad++; $display("FAIL rst_is_write got=%b exp=0", rsp_is_write); end
        total++; if (mem_oce !== 1'b1 || mem_reset !== 1'b0) begin bad++; $display("FAIL rst_tieoffs got=%b%b exp=10", mem_oce, mem_reset); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    endtask

    // Single write or read with rsp_ready high; checks SRAM-side pins and the 2-cycle response.
    task automatic test_single(input string nm, input logic we, input logic [12:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [10:0] exp_ad, input logic [3:0] exp_be,
                               input logic [31:0] exp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, we, a, d, s);
        #1;
        total++; if (mem_ce !== 1'b1 || mem_wre !== we) begin bad++; $display("FAIL %s_ce_wre got=%b%b exp=1%b", nm, mem_ce, mem_wre, we); end
        total++; if (mem_ad !== exp_ad) begin bad++; $display("FAIL %s_ad got=%h exp=%h", nm, mem_ad, exp_ad); end
        total++; if (mem_byte_en !== exp_be) begin bad++; $display("FAIL %s_byte_en got=%h exp=%h", nm, mem_byte_en, exp_be); end
        total++; if (mem_din !== d) begin bad++; $display("FAIL %s_din got=%h exp=%h", nm, mem_din, d); end
        @(negedge clk);
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL %s_n1 got valid=%b busy=%b exp valid=0 busy=1", nm, rsp_valid, busy); end
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL %s_rsp_valid got=%b exp=1", nm, rsp_valid); end
        total++; if (rsp_is_write !== we) begin bad++; $display("FAIL %s_is_write got=%b exp=%b", nm, rsp_is_write, we); end
        total++; if (rsp_rdata !== exp_rdata) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, rsp_rdata, exp_rdata); end
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_idle got valid=%b busy=%b exp 0 0", nm, rsp_valid, busy); end
    endtask

    task automatic test_basic();
        test_single("wr", 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 11'd4, 4'hF, 32'h0);
        test_single("rd", 1'b0, 13'h010, 32'h0, 4'hF, 11'd4, 4'h0, 32'hDEADBEEF);
        test_single("pwr", 1'b1, 13'h010, 32'h11223344, 4'b0101, 11'd4, 4'b0101, 32'h0);
        test_single("prd", 1'b0, 13'h010, 32'h0, 4'h0, 11'd4, 4'h0, 32'hDE22BE44);
        test_single("zwr", 1'b1, 13'h010, 32'hFFFFFFFF, 4'h0, 11'd4, 4'h0, 32'h0);
        test_single("zrd", 1'b0, 13'h010, 32'h0, 4'h0, 11'd4, 4'h0, 32'hDE22BE44);
    endtask

    // Eight writes then eight reads at full rate: responses on consecutive cycles.
    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < 11; j++) begin
                @(negedge clk);
                if (j < 8) drive(1'b1, pass == 0, 13'((16 + j) * 4), 32'hA000_0000 + 32'(j), 4'hF);
                else       drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
                #1;
                if (j < 8) begin
                    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready pass=%0d j=%0d got=%b exp=1", pass, j, req_ready); end
                end
                if (j >= 2 && j < 10) begin
                    total++;
                    if (rsp_valid !== 1'b1 || rsp_is_write !== (pass == 0) ||
                        rsp_rdata !== ((pass == 0) ? 32'h0 : 32'hA000_0000 + 32'(j - 2))) begin
                        bad++;
                        $display("FAIL b2b_rsp pass=%0d j=%0d got v=%b w=%b d=%h", pass, j, rsp_valid, rsp_is_write, rsp_rdata);
                    end
                end
                if (j == 10) begin
                    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", rsp_valid); end
                end
            end
        end
    endtask

    // Stalled consumer: three accepted, then ready drops and the head stays put.
    task automatic test_backpressure();
        int acc = 0;
        rsp_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 13'((16 + acc) * 4), 32'h0, 4'h0);
            #1;
            if (req_ready === 1'b1) acc++;
            if (j >= 2) begin
                total++; if (rsp_rdata !== 32'hA000_0000) begin bad++; $display("FAIL bp_head_stable j=%0d got=%h exp=a0000000", j, rsp_rdata); end
            end
        end
        total++; if (acc != 3) begin bad++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k < 3) begin
                total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL bp_drain k=%0d got v=%b d=%h", k, rsp_valid, rsp_rdata); end
            end else begin
                total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b busy=%b exp 0 0", rsp_valid, busy); end
            end
            @(negedge clk);
        end
    endtask

    // Reset with two buffered responses, then an immediate read after release.
    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        @(negedge clk); drive(1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        @(negedge clk); drive(1'b1, 1'b0, 13'h044, 32'h0, 4'h0);
        @(negedge clk); drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rm_pre got v=%b busy=%b exp 1 1", rsp_valid, busy); end
        #1 resetn = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_async got v=%b busy=%b exp 0 0", rsp_valid, busy); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", rsp_rdata); end
        @(negedge clk);
        resetn = 1'b1; rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        #1;
        total++; if (req_ready !== 1'b1 || mem_ce !== 1'b1) begin bad++; $display("FAIL rm_ready got r=%b ce=%b exp 1 1", req_ready, mem_ce); end
        @(negedge clk); drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL rm_read got v=%b d=%h exp 1 de22be44", rsp_valid, rsp_rdata); end
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_idle got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
